// File: rtl/debug_unit_pkg.sv
// Shared constants and state encoding for the debug-unit program loader.
package debug_unit_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// Shifts bytes MSB-first into a word; flags the byte that completes a word.
module byte_to_word_packer
  import debug_unit_pkg::*;
#(
  parameter int unsigned NB = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          shift_en,
  input  logic [7:0]    in_byte,
  output logic [NB-1:0] word_c,
  output logic          word_ready_c
);

  localparam int unsigned IDX_W = 2;

  logic [NB-1:0]    word_q;
  logic [IDX_W-1:0] idx_q;

  // Word as it will look once the current byte is shifted in.
  assign word_c       = {word_q[NB-BYTE_W-1:0], in_byte};
  assign word_ready_c = shift_en && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_c;
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Assembles UART bytes into instruction words, writes them to IMEM and
// stalls the CPU until the HALT word has been stored.
module imem_loader #(
  parameter int unsigned NB           = 32,
  parameter int unsigned NB_addr_imem = 10,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_start_load,
  input  logic [7:0]              in_byte,
  input  logic                    in_byte_valid,
  output logic                    out_byte_ready,
  output logic                    out_imem_we,
  output logic [NB_addr_imem-1:0] out_imem_addr,
  output logic [NB-1:0]           out_imem_data,
  output logic [NB_addr_imem:0]   out_word_count,
  output logic                    out_loaded,
  output logic                    out_overflow,
  output logic                    out_cpu_stall
);

  import debug_unit_pkg::*;

  localparam int unsigned AW    = NB_addr_imem;
  localparam int unsigned CW    = NB_addr_imem + 1;
  localparam int unsigned DEPTH = 1 << NB_addr_imem;

  loader_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic [AW-1:0] addr_d;
  logic [NB-1:0] data_d, word_c;
  logic          clear_c, shift_en_c, word_ready_c;
  logic          ready_d, we_d, loaded_d, overflow_d, stall_d;

  // Ready is a flop, so acceptance never loops back through in_byte_valid.
  assign shift_en_c = out_byte_ready && in_byte_valid;
  assign count_inc  = count_q + CW'(1);

  byte_to_word_packer #(.NB(NB)) u_packer (
    .clk          (clk),
    .rst_n        (reset),
    .clear        (clear_c),
    .shift_en     (shift_en_c),
    .in_byte      (in_byte),
    .word_c       (word_c),
    .word_ready_c (word_ready_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      out_byte_ready <= 1'b0;
      out_imem_we    <= 1'b0;
      out_imem_addr  <= '0;
      out_imem_data  <= '0;
      out_loaded     <= 1'b0;
      out_overflow   <= 1'b0;
      out_cpu_stall  <= 1'b1;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      out_byte_ready <= ready_d;
      out_imem_we    <= we_d;
      out_imem_addr  <= addr_d;
      out_imem_data  <= data_d;
      out_loaded     <= loaded_d;
      out_overflow   <= overflow_d;
      out_cpu_stall  <= stall_d;
    end
  end

  assign out_word_count = count_q;

  // Next state; registered outputs follow from the state being entered.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clear_c = 1'b0;
    addr_d  = out_imem_addr;
    data_d  = out_imem_data;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (in_start_load) begin
          state_d = RECV;
          count_d = '0;
          clear_c = 1'b1;
        end
      end
      RECV: begin
        if (in_start_load) begin
          count_d = '0;
          clear_c = 1'b1;
        end else if (word_ready_c) begin
          state_d = WRITE;
          addr_d  = count_q[AW-1:0];
          data_d  = word_c;
        end
      end
      WRITE: begin
        clear_c = 1'b1;
        count_d = count_inc;
        // A start seen during the write cycle restarts on the closing edge.
        if (in_start_load) begin
          state_d = RECV;
          count_d = '0;
        end else if (out_imem_data == HALT_WORD) begin
          state_d = DONE;
        end else if (count_inc == CW'(DEPTH)) begin
          state_d = ERROR;
        end else begin
          state_d = RECV;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        clear_c = 1'b1;
      end
    endcase

    ready_d    = (state_d == RECV);
    we_d       = (state_d == WRITE);
    loaded_d   = (state_d == DONE);
    overflow_d = (state_d == ERROR);
    stall_d    = (state_d != DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory (NB_addr_imem=2).
module tb_imem_loader;

  localparam int unsigned AW = 2;

  logic          clk;
  logic          reset;
  logic          in_start_load;
  logic [7:0]    in_byte;
  logic          in_byte_valid;
  logic          out_byte_ready;
  logic          out_imem_we;
  logic [AW-1:0] out_imem_addr;
  logic [31:0]   out_imem_data;
  logic [AW:0]   out_word_count;
  logic          out_loaded;
  logic          out_overflow;
  logic          out_cpu_stall;

  int checks;
  int errors;
  int wr_n;
  logic [AW-1:0] log_addr [0:63];
  logic [31:0]   log_data [0:63];

  imem_loader #(.NB(32), .NB_addr_imem(AW), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_start_load  (in_start_load),
    .in_byte        (in_byte),
    .in_byte_valid  (in_byte_valid),
    .out_byte_ready (out_byte_ready),
    .out_imem_we    (out_imem_we),
    .out_imem_addr  (out_imem_addr),
    .out_imem_data  (out_imem_data),
    .out_word_count (out_word_count),
    .out_loaded     (out_loaded),
    .out_overflow   (out_overflow),
    .out_cpu_stall  (out_cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write seen on the memory port.
  always @(posedge clk) begin
    if (out_imem_we === 1'b1 && wr_n < 64) begin
      log_addr[wr_n] = out_imem_addr;
      log_data[wr_n] = out_imem_data;
      wr_n = wr_n + 1;
    end
  end

  task automatic pulse_start();
    in_start_load = 1'b1;
    @(posedge clk); #1;
    in_start_load = 1'b0;
  endtask

  // Hold the byte until it is accepted; returns #1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_byte = b;
    in_byte_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (out_byte_ready !== 1'b1 && t < 50) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (out_byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_timeout: byte %h ready=%b want 1", b, out_byte_ready);
    end
    @(posedge clk); #1;
    in_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++)
      send_byte(w[31-8*i -: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic check_write(input string name, input int idx, input logic [AW-1:0] a,
                             input logic [31:0] d);
    checks++;
    if (wr_n <= idx || log_addr[idx] !== a || log_data[idx] !== d) begin
      errors++;
      $display("FAIL %s: writes=%0d addr=%0d data=%h want idx %0d addr=%0d data=%h",
               name, wr_n, log_addr[idx], log_data[idx], idx, a, d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_byte_ready, out_imem_we, out_imem_addr, out_imem_data, out_word_count,
         out_loaded, out_overflow, out_cpu_stall} !== {1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%0d data=%h cnt=%0d ld=%b ov=%b st=%b want 0 0 0 0 0 0 0 1",
               out_byte_ready, out_imem_we, out_imem_addr, out_imem_data, out_word_count,
               out_loaded, out_overflow, out_cpu_stall);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_byte_ready !== 1'b0 || out_cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL idle_outputs: rdy=%b st=%b want 0 1", out_byte_ready, out_cpu_stall);
    end
  endtask

  task automatic test_basic();
    int n0;
    n0 = wr_n;
    pulse_start();
    checks++;
    if (out_byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_after_start: got %b want 1", out_byte_ready);
    end
    send_word(32'h3C00_0001, 0);
    checks++;
    if (out_imem_we !== 1'b1 || out_imem_addr !== 2'd0 || out_imem_data !== 32'h3C00_0001 ||
        out_byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_write_cycle: we=%b addr=%0d data=%h rdy=%b want 1 0 3c000001 0",
               out_imem_we, out_imem_addr, out_imem_data, out_byte_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_imem_we !== 1'b0 || out_byte_ready !== 1'b1 || out_word_count !== 3'd1 ||
        wr_n != n0 + 1) begin
      errors++;
      $display("FAIL basic_after_write: we=%b rdy=%b cnt=%0d writes=%0d want 0 1 1 %0d",
               out_imem_we, out_byte_ready, out_word_count, wr_n - n0, 1);
    end
  endtask

  task automatic test_halt();
    int n0;
    n0 = wr_n;
    send_word(32'h2020_0001, 0);
    send_word(32'hFFFF_FFFF, 0);
    check_write("halt_word1", n0, 2'd1, 32'h2020_0001);
    @(posedge clk); #1;
    check_write("halt_word2", n0 + 1, 2'd2, 32'hFFFF_FFFF);
    checks++;
    if (out_loaded !== 1'b1 || out_cpu_stall !== 1'b0 || out_word_count !== 3'd3 ||
        out_byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL halt_done: ld=%b st=%b cnt=%0d rdy=%b want 1 0 3 0",
               out_loaded, out_cpu_stall, out_word_count, out_byte_ready);
    end
  endtask

  task automatic test_restart_mid_word();
    int n0;
    pulse_start();
    checks++;
    if (out_loaded !== 1'b0 || out_cpu_stall !== 1'b1 || out_word_count !== 3'd0) begin
      errors++;
      $display("FAIL restart_from_done: ld=%b st=%b cnt=%0d want 0 1 0",
               out_loaded, out_cpu_stall, out_word_count);
    end
    n0 = wr_n;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    send_word(32'hAABB_CCDD, 0);
    @(posedge clk); #1;
    checks++;
    if (wr_n != n0 + 1) begin
      errors++;
      $display("FAIL restart_write_count: got %0d want 1", wr_n - n0);
    end
    check_write("restart_word", n0, 2'd0, 32'hAABB_CCDD);
  endtask

  task automatic test_backpressure_halt_last();
    int n0;
    pulse_start();
    n0 = wr_n;
    send_word(32'h0102_0304, 2);
    send_word(32'h0506_0708, 2);
    send_word(32'h090A_0B0C, 2);
    send_word(32'hFFFF_FFFF, 2);
    @(posedge clk); #1;
    check_write("bp_w0", n0,     2'd0, 32'h0102_0304);
    check_write("bp_w1", n0 + 1, 2'd1, 32'h0506_0708);
    check_write("bp_w2", n0 + 2, 2'd2, 32'h090A_0B0C);
    check_write("bp_halt_last", n0 + 3, 2'd3, 32'hFFFF_FFFF);
    checks++;
    if (wr_n != n0 + 4 || out_loaded !== 1'b1 || out_overflow !== 1'b0 ||
        out_word_count !== 3'd4) begin
      errors++;
      $display("FAIL bp_done: writes=%0d ld=%b ov=%b cnt=%0d want 4 1 0 4",
               wr_n - n0, out_loaded, out_overflow, out_word_count);
    end
  endtask

  task automatic test_overflow();
    int n0;
    pulse_start();
    n0 = wr_n;
    for (int i = 0; i < 4; i++) send_word(32'h1000_0000 + i, 0);
    @(posedge clk); #1;
    check_write("ovf_last", n0 + 3, 2'd3, 32'h1000_0003);
    checks++;
    if (out_overflow !== 1'b1 || out_cpu_stall !== 1'b1 || out_loaded !== 1'b0 ||
        out_byte_ready !== 1'b0 || out_word_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_error: ov=%b st=%b ld=%b rdy=%b cnt=%0d want 1 1 0 0 4",
               out_overflow, out_cpu_stall, out_loaded, out_byte_ready, out_word_count);
    end
    pulse_start();
    checks++;
    if (out_overflow !== 1'b0 || out_byte_ready !== 1'b1 || out_word_count !== 3'd0) begin
      errors++;
      $display("FAIL ovf_restart: ov=%b rdy=%b cnt=%0d want 0 1 0",
               out_overflow, out_byte_ready, out_word_count);
    end
  endtask

  task automatic test_start_during_write();
    int n0;
    n0 = wr_n;
    send_word(32'h0102_0304, 0);
    pulse_start();
    check_write("sdw_write", n0, 2'd0, 32'h0102_0304);
    checks++;
    if (out_word_count !== 3'd0 || out_byte_ready !== 1'b1 || out_imem_we !== 1'b0) begin
      errors++;
      $display("FAIL sdw_restart: cnt=%0d rdy=%b we=%b want 0 1 0",
               out_word_count, out_byte_ready, out_imem_we);
    end
    send_word(32'hDEAD_BEEF, 0);
    @(posedge clk); #1;
    check_write("sdw_next", n0 + 1, 2'd0, 32'hDEAD_BEEF);
  endtask

  task automatic test_async_reset();
    int n0;
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_byte_ready !== 1'b0 || out_cpu_stall !== 1'b1 || out_word_count !== 3'd0 ||
        out_imem_we !== 1'b0 || out_loaded !== 1'b0 || out_imem_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b st=%b cnt=%0d we=%b ld=%b data=%h want 0 1 0 0 0 0",
               out_byte_ready, out_cpu_stall, out_word_count, out_imem_we, out_loaded, out_imem_data);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    n0 = wr_n;
    pulse_start();
    send_word(32'h1234_5678, 0);
    @(posedge clk); #1;
    check_write("async_after", n0, 2'd0, 32'h1234_5678);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_n = 0;
    in_start_load = 1'b0;
    in_byte = 8'h00;
    in_byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_halt();
    test_restart_mid_word();
    test_backpressure_halt_last();
    test_overflow();
    test_start_during_write();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
